dff_monitor: RTL

DFF_MONITOR -- requirements
Module: dff_monitor

---
 rtl/dff_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dff_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dff_monitor
// Description : Watches a flip-flop with synchronous reset/set/enable and
//               checks its q / q_n outputs against an internal reference
//               model of the same flop. After enable, the monitor waits in
//               SYNC for the first control event. That event gives it a known
//               state. From then on, every edge in CHECK compares the outputs
//               against the model state from the previous edge.
// Revision    : 1.0 - initial release
//
// Parameters
//   ERR_CNT_W  width of the saturating mismatch counter
//   CHK_CNT_W  width of the saturating compare counter, cycle counter and
//              captured failure cycle
//
// Ports
//   clk         rising-edge clock for every flop
//   reset       synchronous active-high monitor reset (highest priority)
//   mon_en      monitor enable; low drops to IDLE and discards the model
//   obs_d       observed flop data input
//   obs_reset   observed flop reset input (priority over set)
//   obs_set     observed flop set input (priority over enable)
//   obs_enable  observed flop load enable
//   obs_q       observed flop output
//   obs_q_n     observed flop inverted output
//   synced      high while in CHECK
//   err         sticky mismatch flag
//   err_cnt     saturating mismatch count
//   chk_cnt     saturating count of compares performed
//   fail_cycle  CHECK-cycle index of the first mismatch (capture build only)
//   fail_exp    model q at the first mismatch (capture build only)
//
// Build option
//   DFF_MON_CAPTURE_EN  when defined, adds the CHECK cycle counter and the
//                       first-failure capture registers. Otherwise
//                       fail_cycle and fail_exp are tied to 0.
// ============================================================================
module dff_monitor #(
  parameter int ERR_CNT_W = 8,
  parameter int CHK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mon_en,
  input  logic                 obs_d,
  input  logic                 obs_reset,
  input  logic                 obs_set,
  input  logic                 obs_enable,
  input  logic                 obs_q,
  input  logic                 obs_q_n,
  output logic                 synced,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CHK_CNT_W-1:0] chk_cnt,
  output logic [CHK_CNT_W-1:0] fail_cycle,
  output logic                 fail_exp
);

  localparam logic [ERR_CNT_W-1:0] c_err_one = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CHK_CNT_W-1:0] c_chk_one = {{(CHK_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 exp_q, exp_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CHK_CNT_W-1:0] chk_cnt_q, chk_cnt_d;

  logic w_ctl_any;
  logic w_ref_next;
  logic w_mismatch;
  logic w_do_cmp;

  // Reference flop next state: reset beats set, and set beats enable.
  assign w_ctl_any  = obs_reset | obs_set | obs_enable;
  assign w_ref_next = obs_reset  ? 1'b0 :
                      obs_set    ? 1'b1 :
                      obs_enable ? obs_d : exp_q;

  // A wrong q, a wrong q_n, or both wrong counts as a single mismatch.
  assign w_mismatch = (obs_q != exp_q) || (obs_q_n != ~exp_q);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    w_do_cmp  = 1'b0;

    if (!mon_en) begin
      // A disable ends the session. Do no compare on this edge and clear
      // the model so the next session has to sync again.
      state_d = S_IDLE;
      exp_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SYNC;
        S_SYNC: begin
          // The first control event puts the observed flop in a known state.
          if (w_ctl_any) begin
            exp_d   = w_ref_next;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          w_do_cmp = 1'b1;
          exp_d    = w_ref_next;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (w_do_cmp) begin
      if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + c_chk_one;
      if (w_mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + c_err_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      exp_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign synced  = (state_q == S_CHECK);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign chk_cnt = chk_cnt_q;

`ifdef DFF_MON_CAPTURE_EN
  logic [CHK_CNT_W-1:0] cyc_q, cyc_d;
  logic [CHK_CNT_W-1:0] fail_cycle_q, fail_cycle_d;
  logic                 fail_exp_q, fail_exp_d;

  // The sticky err flag shows that the first failure is already captured.
  always_comb begin
    cyc_d        = cyc_q;
    fail_cycle_d = fail_cycle_q;
    fail_exp_d   = fail_exp_q;
    if (w_do_cmp) begin
      if (cyc_q != '1) cyc_d = cyc_q + c_chk_one;
      if (w_mismatch && !err_q) begin
        fail_cycle_d = cyc_q;
        fail_exp_d   = exp_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q        <= '0;
      fail_cycle_q <= '0;
      fail_exp_q   <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      fail_cycle_q <= fail_cycle_d;
      fail_exp_q   <= fail_exp_d;
    end
  end

  assign fail_cycle = fail_cycle_q;
  assign fail_exp   = fail_exp_q;
`else
  assign fail_cycle = '0;
  assign fail_exp   = 1'b0;
`endif

endmodule
`default_nettype wire
